// File: rtl/seq_pattern_tx_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the 5-bit sequence link: pattern constants, the
// select codes used by both transmitter and detector, the transmitter state
// encoding and a parity helper.
// No ports (package).
// ----------------------------------------------------------------------------
package seq_pkg;

    localparam int PAT_LEN = 5;

    // Select codes shared with the detector
    localparam logic [1:0] SEL_00 = 2'b00;
    localparam logic [1:0] SEL_01 = 2'b01;
    localparam logic [1:0] SEL_10 = 2'b10;
    localparam logic [1:0] SEL_11 = 2'b11;

    // Patterns, transmitted MSB first
    localparam logic [PAT_LEN-1:0] PAT_00 = 5'b10111;
    localparam logic [PAT_LEN-1:0] PAT_01 = 5'b01010;
    localparam logic [PAT_LEN-1:0] PAT_10 = 5'b10101;
    localparam logic [PAT_LEN-1:0] PAT_11 = 5'b10100;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        PAR  = 3'd2,
        GAP  = 3'd3,
        FIN  = 3'd4
    } seq_state_t;

    // Even-parity bit of a pattern (XOR of all bits)
    function automatic logic pat_parity(input logic [PAT_LEN-1:0] pat);
        return ^pat;
    endfunction

endpackage

// File: rtl/seq_pattern_tx_rom.sv
// ----------------------------------------------------------------------------
// seq_pattern_rom
// Combinational lookup from the 2-bit select code to the 5-bit pattern.
// Also used by the detector's reference model.
// Ports:
//   i_sel     [1:0]  pattern select code
//   o_pattern [4:0]  selected pattern, MSB transmitted first
// ----------------------------------------------------------------------------
module seq_pattern_rom
    import seq_pkg::*;
(
    input  logic [1:0]         i_sel,
    output logic [PAT_LEN-1:0] o_pattern
);

    always_comb begin
        o_pattern = PAT_00;
        case (i_sel)
            SEL_00:  o_pattern = PAT_00;
            SEL_01:  o_pattern = PAT_01;
            SEL_10:  o_pattern = PAT_10;
            SEL_11:  o_pattern = PAT_11;
            default: o_pattern = PAT_00;
        endcase
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// ----------------------------------------------------------------------------
// seq_pattern_tx
// Serial pattern transmitter for the 5-bit sequence-detector link. On a start
// request it sends the selected pattern MSB-first, one bit per clock, for
// repeat_count repetitions separated by GAP_CYCLES idle bit-times.
// All outputs are registered: the FSM decodes its outputs combinationally from
// the current state and they are captured on the next rising edge, so the
// first bit appears one edge after start is sampled.
//
// Optional build macro: SEQ_PATTERN_TX_PARITY_EN -- appends one even-parity
// bit after every pattern (6 bit-times per frame).
//
// Parameters:
//   REP_W       width of repeat_count
//   GAP_CYCLES  idle bit-times between repetitions (0..15)
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high
//   start         request pulse, honoured only when idle
//   lookfor_seq   pattern select (latched at start)
//   repeat_count  number of repetitions (latched at start)
//   serial_out    transmitted bit, 0 when out_valid=0
//   out_valid     serial_out carries a pattern/parity bit
//   busy          transfer in progress
//   done          one-cycle pulse at end of transfer
//   sent_count    completed patterns since reset, saturating
// ----------------------------------------------------------------------------
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int REP_W      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       lookfor_seq,
    input  logic [REP_W-1:0] repeat_count,
    output logic             serial_out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [15:0]      sent_count
);

    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    seq_state_t         r_state;
    logic [2:0]         r_idx;
    logic [PAT_LEN-1:0] r_pat;
    logic [REP_W-1:0]   r_remain;
    logic [3:0]         r_gap_cnt;
    logic               r_serial_out;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_done;
    logic [15:0]        r_sent_count;

    seq_state_t         w_state_nxt;
    logic [2:0]         w_idx_nxt;
    logic [PAT_LEN-1:0] w_pat_nxt;
    logic [REP_W-1:0]   w_remain_nxt;
    logic [3:0]         w_gap_nxt;
    logic [15:0]        w_sent_nxt;
    logic               w_serial;
    logic               w_valid;
    logic               w_busy;
    logic               w_done;
    logic               w_end_pat;
    logic [PAT_LEN-1:0] w_rom_pat;

    seq_pattern_rom u_rom (
        .i_sel     (lookfor_seq),
        .o_pattern (w_rom_pat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_pat        <= '0;
            r_remain     <= '0;
            r_gap_cnt    <= '0;
            r_serial_out <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sent_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_pat        <= w_pat_nxt;
            r_remain     <= w_remain_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_serial_out <= w_serial;
            r_out_valid  <= w_valid;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_sent_count <= w_sent_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_pat_nxt    = r_pat;
        w_remain_nxt = r_remain;
        w_gap_nxt    = r_gap_cnt;
        w_sent_nxt   = r_sent_count;
        w_serial     = 1'b0;
        w_valid      = 1'b0;
        w_busy       = (r_state != IDLE);
        w_done       = 1'b0;
        w_end_pat    = 1'b0;

        case (r_state)
            IDLE: begin
                // r_busy still shows the done cycle of the previous transfer;
                // start is refused until the visible busy has dropped.
                if (start && !r_busy) begin
                    if (repeat_count != '0) begin
                        w_state_nxt  = SEND;
                        w_idx_nxt    = 3'd4;
                        w_pat_nxt    = w_rom_pat;
                        w_remain_nxt = repeat_count;
                    end else begin
                        w_state_nxt  = FIN;
                    end
                end
            end
            SEND: begin
                w_serial = r_pat[r_idx];
                w_valid  = 1'b1;
                if (r_idx == 3'd0) begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    w_state_nxt = PAR;
`else
                    w_end_pat   = 1'b1;
`endif
                end else begin
                    w_idx_nxt = r_idx - 3'd1;
                end
            end
`ifdef SEQ_PATTERN_TX_PARITY_EN
            PAR: begin
                w_serial  = pat_parity(r_pat);
                w_valid   = 1'b1;
                w_end_pat = 1'b1;
            end
`endif
            GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_nxt = SEND;
                    w_idx_nxt   = 3'd4;
                end else begin
                    w_gap_nxt   = r_gap_cnt - 4'd1;
                end
            end
            FIN: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // End-of-pattern decision, shared by the SEND and PAR exits
        if (w_end_pat) begin
            if (r_sent_count != 16'hFFFF) begin
                w_sent_nxt = r_sent_count + 16'd1;
            end
            if (r_remain <= REP_W'(1)) begin
                w_remain_nxt = '0;
                w_state_nxt  = FIN;
            end else begin
                w_remain_nxt = r_remain - REP_W'(1);
                if (GAP_CYCLES == 0) begin
                    w_state_nxt = SEND;
                    w_idx_nxt   = 3'd4;
                end else begin
                    w_state_nxt = GAP;
                    w_gap_nxt   = GAP_LAST;
                end
            end
        end
    end

    assign serial_out = r_serial_out;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sent_count = r_sent_count;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// ----------------------------------------------------------------------------
// tb_seq_pattern_tx
// Directed bench for seq_pattern_tx (REP_W=8, GAP_CYCLES=2). Inputs are
// driven 1 time unit after each rising edge and outputs sampled at that point.
// ----------------------------------------------------------------------------
module tb_seq_pattern_tx;

    localparam int REP_W = 8;
    localparam int GAP   = 2;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       lookfor_seq;
    logic [REP_W-1:0] repeat_count;
    logic             serial_out;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic [15:0]      sent_count;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int busy_mark;

    seq_pattern_tx #(.REP_W(REP_W), .GAP_CYCLES(GAP)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .lookfor_seq  (lookfor_seq),
        .repeat_count (repeat_count),
        .serial_out   (serial_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .done         (done),
        .sent_count   (sent_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy === 1'b1) busy_cnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check one full frame: 5 pattern bits MSB first, then parity if built in
    task automatic expect_frame(input string tag, input logic [4:0] pat);
        for (int i = 4; i >= 0; i--) begin
            tick();
            chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_bit"},   {31'd0, serial_out}, {31'd0, pat[i]});
            chk({tag, "_busy"},  {31'd0, busy}, 32'd1);
            chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
        end
        if (PBITS == 1) begin
            tick();
            chk({tag, "_pvalid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_pbit"},   {31'd0, serial_out}, {31'd0, ^pat});
        end
    endtask

    task automatic expect_gap(input string tag);
        for (int i = 0; i < GAP; i++) begin
            tick();
            chk({tag, "_gvalid"}, {31'd0, out_valid}, 32'd0);
            chk({tag, "_gbit"},   {31'd0, serial_out}, 32'd0);
            chk({tag, "_gbusy"},  {31'd0, busy}, 32'd1);
        end
    endtask

    task automatic expect_done(input string tag, input logic [15:0] cnt);
        tick();
        chk({tag, "_done"},  {31'd0, done}, 32'd1);
        chk({tag, "_dbusy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_dvld"},  {31'd0, out_valid}, 32'd0);
        chk({tag, "_cnt"},   {16'd0, sent_count}, {16'd0, cnt});
        tick();
        chk({tag, "_done0"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"},  {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        lookfor_seq  = 2'b00;
        repeat_count = '0;
        tick();
        tick();
        chk("rst_serial", {31'd0, serial_out}, 32'd0);
        chk("rst_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_done",   {31'd0, done}, 32'd0);
        chk("rst_cnt",    {16'd0, sent_count}, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Single pattern 00 -> 10111, done at N+6
        lookfor_seq  = 2'b00;
        repeat_count = 8'd1;
        start        = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_lat", {31'd0, out_valid}, 32'd0);
        busy_mark = busy_cnt;
        expect_frame("t1", 5'b10111);
        expect_done("t1", 16'd1);
        chk("t1_busycyc", busy_cnt - busy_mark, 32'(5 + PBITS + 1));

        // Three repetitions of 01010 with 2-cycle gaps
        lookfor_seq  = 2'b01;
        repeat_count = 8'd3;
        start        = 1'b1;
        tick();
        start = 1'b0;
        busy_mark = busy_cnt;
        expect_frame("t2a", 5'b01010);
        expect_gap("t2a");
        expect_frame("t2b", 5'b01010);
        expect_gap("t2b");
        expect_frame("t2c", 5'b01010);
        expect_done("t2", 16'd4);
        chk("t2_busycyc", busy_cnt - busy_mark, 32'(3 * (5 + PBITS) + 2 * GAP + 1));

        // repeat_count=0: done one cycle after start, nothing sent
        repeat_count = 8'd0;
        start        = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_vld0", {31'd0, out_valid}, 32'd0);
        expect_done("t3", 16'd4);

        // Reset during the third bit of 10101
        lookfor_seq  = 2'b10;
        repeat_count = 8'd2;
        start        = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t4_b4", {31'd0, serial_out}, 32'd1);
        tick();
        chk("t4_b3", {31'd0, serial_out}, 32'd0);
        tick();
        chk("t4_b2", {31'd0, serial_out}, 32'd1);
        reset = 1'b1;
        tick();
        chk("t4_serial", {31'd0, serial_out}, 32'd0);
        chk("t4_valid",  {31'd0, out_valid}, 32'd0);
        chk("t4_busy",   {31'd0, busy}, 32'd0);
        chk("t4_done",   {31'd0, done}, 32'd0);
        chk("t4_cnt",    {16'd0, sent_count}, 32'd0);
        reset        = 1'b0;
        repeat_count = 8'd1;
        start        = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_nodone", {31'd0, done}, 32'd0);
        expect_frame("t4r", 5'b10101);
        expect_done("t4r", 16'd1);

        // Re-start and select change mid-transfer are ignored
        lookfor_seq  = 2'b00;
        repeat_count = 8'd1;
        start        = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t5_b4", {31'd0, serial_out}, 32'd1);
        tick();
        chk("t5_b3", {31'd0, serial_out}, 32'd0);
        start        = 1'b1;
        lookfor_seq  = 2'b11;
        repeat_count = 8'd5;
        tick();
        start = 1'b0;
        chk("t5_b2", {31'd0, serial_out}, 32'd1);
        tick();
        chk("t5_b1", {31'd0, serial_out}, 32'd1);
        tick();
        chk("t5_b0", {31'd0, serial_out}, 32'd1);
        if (PBITS == 1) begin
            tick();
            chk("t5_par", {31'd0, serial_out}, 32'd0);
        end
        // start held across the FIN->IDLE edge and the done cycle is ignored
        start = 1'b1;
        tick();
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_cnt",  {16'd0, sent_count}, 32'd2);
        tick();
        start = 1'b0;
        chk("t5_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("t5_norestart_busy", {31'd0, busy}, 32'd0);
        chk("t5_norestart_vld",  {31'd0, out_valid}, 32'd0);

        // Start accepted right after busy falls: pattern 11 -> 10100
        lookfor_seq  = 2'b11;
        repeat_count = 8'd1;
        start        = 1'b1;
        tick();
        start = 1'b0;
        expect_frame("t6", 5'b10100);
        expect_done("t6", 16'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
